// File: rtl/time_data_fifo_if.sv
// Measurement-result bus: 64-bit write strobe on one side, 32-bit word stream on the other.
interface time_data_fifo_if;
  // done qualifies timedata for exactly one cycle (no back-pressure on writes).
  // A read word transfers on any rising edge where rd_valid && rd_ready; while
  // rd_valid is high and rd_ready low, rd_data/rd_last hold stable.
  logic [63:0] timedata;
  logic        done;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;

  modport slave (
    input  timedata, done, rd_ready,
    output rd_valid, rd_data, rd_last
  );

  modport master (
    output timedata, done, rd_ready,
    input  rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/time_data_fifo.sv
// Buffers 64-bit measurement results and streams each out as two 32-bit words,
// low word first, counting results dropped when the buffer is full.
module time_data_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  time_data_fifo_if.slave   bus,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } rd_state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

  rd_state_t         state_q, state_d;
  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [ADDR_W:0]   count_q;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              pop, wr_en, drop;

  assign rd_ptr_next = rd_ptr + ADDR_W'(1);
  assign pop   = (state_q == HIGH) && rd_valid_q && bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign wr_en = bus.done && ((count_q != FULL_COUNT) || pop);
  assign drop  = bus.done && !wr_en;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          rd_data_d  = mem[rd_ptr][31:0];
          rd_last_d  = 1'b0;
          rd_valid_d = 1'b1;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (bus.rd_ready) begin
          rd_data_d = mem[rd_ptr][63:32];
          rd_last_d = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (bus.rd_ready) begin
          // Only entries already stored before this edge are eligible; a
          // same-cycle write is picked up from IDLE one cycle later.
          if (count_q > ONE_COUNT) begin
            rd_data_d = mem[rd_ptr_next][31:0];
            rd_last_d = 1'b0;
            state_d   = LOW;
          end else begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        rd_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset && !clear) begin
      mem[wr_ptr] <= bus.timedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr_next;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + ONE_COUNT;
        2'b01:   count_q <= count_q - ONE_COUNT;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = rd_last_q;
  assign fifo_count   = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_time_data_fifo.sv
// Directed bench for time_data_fifo: latency, back-pressure, overflow,
// full-buffer write with pop, gapless streaming and clear mid-transfer.
module tb_time_data_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  time_data_fifo_if bus();

  time_data_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [63:0] v);
    bus.timedata = v;
    bus.done     = 1'b1;
    tick();
    bus.done     = 1'b0;
  endtask

  task automatic queue_entry(input logic [63:0] v);
    exp_q.push_back(v[31:0]);
    exp_q.push_back(v[63:32]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.rd_valid, 0);
    check({tag, "_data"},  bus.rd_data,  0);
    check({tag, "_last"},  bus.rd_last,  0);
    check({tag, "_count"}, fifo_count,   0);
    check({tag, "_ovf"},   overflow,     0);
    check({tag, "_drop"},  drop_cnt,     0);
    check({tag, "_state"}, dbg_state,    0);
  endtask

  // scoreboard: consume n words against exp_q with rd_ready held high
  task automatic drain(input int n, input bit gapless);
    int waited;
    logic [31:0] exp_word;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      if (gapless) check("gapless_valid", bus.rd_valid, 1);
      while (!bus.rd_valid && waited < 10) begin
        tick();
        waited++;
      end
      if (!bus.rd_valid) begin
        check("drain_timeout", 0, 1);
        return;
      end
      if (exp_q.size() == 0) begin
        check("drain_extra_word", 1, 0);
        return;
      end
      exp_word = exp_q.pop_front();
      check("drain_data", bus.rd_data, exp_word);
      check("drain_last", bus.rd_last, 64'(i % 2));
      tick();
    end
  endtask

  initial begin
    bus.timedata = '0;
    bus.done     = 1'b0;
    bus.rd_ready = 1'b0;
    clear        = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // single result: low word one edge after the write, then high, then idle
    bus.rd_ready = 1'b1;
    push_result(64'h0000_0012_3456_789A);
    check("t1_count_n", fifo_count, 1);
    check("t1_valid_n", bus.rd_valid, 0);
    tick();
    check("t1_valid_lo", bus.rd_valid, 1);
    check("t1_data_lo",  bus.rd_data, 32'h3456_789A);
    check("t1_last_lo",  bus.rd_last, 0);
    tick();
    check("t1_data_hi",  bus.rd_data, 32'h0000_0012);
    check("t1_last_hi",  bus.rd_last, 1);
    tick();
    check("t1_valid_end", bus.rd_valid, 0);
    check("t1_count_end", fifo_count, 0);

    // back-pressure: word held stable while rd_ready is low
    bus.rd_ready = 1'b0;
    push_result(64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check("t2_valid", bus.rd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_data", bus.rd_data, 32'hCCCC_DDDD);
      check("t2_hold_last", bus.rd_last, 0);
    end
    queue_entry(64'hAAAA_BBBB_CCCC_DDDD);
    drain(2, 1'b0);
    check("t2_valid_end", bus.rd_valid, 0);
    check("t2_count_end", fifo_count, 0);
    check("t2_all_words", 64'(exp_q.size()), 0);

    // fill and overflow: 18 results into 16 slots
    bus.rd_ready = 1'b0;
    for (int i = 1; i <= 18; i++) push_result(64'(i));
    check("t3_count", fifo_count, 16);
    check("t3_ovf",   overflow, 1);
    check("t3_drop",  drop_cnt, 2);
    check("t3_data_lo", bus.rd_data, 1);
    check("t3_last_lo", bus.rd_last, 0);

    // write coincident with the final handshake of a full buffer
    bus.rd_ready = 1'b1;
    tick();
    check("t4_data_hi", bus.rd_data, 0);
    check("t4_last_hi", bus.rd_last, 1);
    bus.timedata = 64'h0000_0099_0000_0011;
    bus.done     = 1'b1;
    tick();
    bus.done     = 1'b0;
    check("t4_count", fifo_count, 16);
    check("t4_drop",  drop_cnt, 2);
    check("t4_nobubble_valid", bus.rd_valid, 1);
    check("t4_next_lo", bus.rd_data, 2);
    for (int i = 2; i <= 16; i++) queue_entry(64'(i));
    queue_entry(64'h0000_0099_0000_0011);
    drain(32, 1'b1);
    check("t4_valid_end", bus.rd_valid, 0);
    check("t4_count_end", fifo_count, 0);

    // back-to-back delivery of three queued results
    bus.rd_ready = 1'b0;
    push_result(64'h1111_2222_3333_4444);
    push_result(64'h5555_6666_7777_8888);
    push_result(64'h9999_AAAA_BBBB_CCCC);
    queue_entry(64'h1111_2222_3333_4444);
    queue_entry(64'h5555_6666_7777_8888);
    queue_entry(64'h9999_AAAA_BBBB_CCCC);
    check("t5_count", fifo_count, 3);
    drain(6, 1'b1);
    check("t5_valid_end", bus.rd_valid, 0);
    check("t5_count_end", fifo_count, 0);

    // clear flushes the sticky status
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ovf",  overflow, 0);
    check("clr_drop", drop_cnt, 0);

    // clear mid-transfer with 4 entries and drop_cnt=3
    bus.rd_ready = 1'b0;
    for (int i = 1; i <= 19; i++) push_result({32'hF000_0000 | 32'(i), 32'(i)});
    check("t6_count_full", fifo_count, 16);
    check("t6_drop", drop_cnt, 3);
    for (int i = 1; i <= 12; i++) queue_entry({32'hF000_0000 | 32'(i), 32'(i)});
    drain(24, 1'b1);
    check("t6_count4", fifo_count, 4);
    check("t6_data13_lo", bus.rd_data, 32'd13);
    tick();
    check("t6_state_high", dbg_state, 2);
    check("t6_data13_hi", bus.rd_data, 32'hF000_000D);
    clear        = 1'b1;
    bus.timedata = 64'hDEAD_BEEF_CAFE_F00D;
    bus.done     = 1'b1;
    tick();
    clear    = 1'b0;
    bus.done = 1'b0;
    exp_q.delete();
    check_reset_outputs("t6_clear");
    tick();
    check("t6_not_stored", fifo_count, 0);
    check("t6_not_valid",  bus.rd_valid, 0);
    push_result(64'h0123_4567_89AB_CDEF);
    check("t6_new_count", fifo_count, 1);
    check("t6_new_valid_n", bus.rd_valid, 0);
    tick();
    check("t6_new_valid", bus.rd_valid, 1);
    queue_entry(64'h0123_4567_89AB_CDEF);
    drain(2, 1'b1);
    check("t6_count_end", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_data_fifo.md
# time_data_fifo

Result buffer on the consumer side of the measurement-result interface. It captures each 64-bit `timedata` result, qualified by the one-cycle `done` strobe from the measurement data-handling block, into a FIFO. It then delivers each result to the SDK/processor side as two 32-bit words over a valid/ready handshake, low word first, for SD-card storage. It also counts results dropped on overflow, so software can detect lost measurements.

## Interface
- `DEPTH`, default 16: FIFO entries (64-bit each). Must be a power of 2, minimum 2.
- `ADDR_W`, default 4: log2(`DEPTH`).
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `timedata`, in, 64: measurement result. Valid only in the cycle `done` is high.
- `done`, in, 1: one-cycle strobe that writes `timedata`.
- `clear`, in, 1: synchronous flush of FIFO, status and counters.
- `rd_ready`, in, 1: consumer accepts `rd_data` this cycle.
- `rd_valid`, out, 1: `rd_data` holds a valid word.
- `rd_data`, out, 32: output word.
- `rd_last`, out, 1: high when `rd_data` is the upper word [63:32].
- `fifo_count`, out, ADDR_W+1: stored entries, including the entry currently being presented.
- `overflow`, out, 1: sticky flag. Set when a result is dropped.
- `drop_cnt`, out, 16: saturating count of dropped results.

## Operation
- **Write side**
  - `done` is accepted when `fifo_count < DEPTH`, or when a pop occurs in the same cycle.
  - An accepted write stores the value at the write pointer and increments the write pointer (wraps modulo `DEPTH`).
  - A rejected write (full, no same-cycle pop) is discarded. `overflow` is set to 1 and `drop_cnt` increments, saturating at 16'hFFFF.
- **Read FSM**: states `IDLE`, `LOW`, `HIGH`.
  - `IDLE`: `rd_valid`=0. If `fifo_count != 0`, register `rd_data` = head[31:0], `rd_last`=0, `rd_valid`=1, and go to `LOW`.
  - `LOW`: on `rd_valid & rd_ready`, register `rd_data` = head[63:32], `rd_last`=1, and go to `HIGH`.
  - `HIGH`: on `rd_valid & rd_ready`, pop the head (read pointer +1, count −1).
    - If another entry remains after the pop, load its low word directly and go to `LOW`. There is no bubble.
    - Otherwise `rd_valid`=0 and go to `IDLE`.
  - While `rd_valid & !rd_ready`, `rd_data` and `rd_last` hold stable.
  - An entry is popped only after its upper word is accepted. A partially read entry stays counted.
- **Count**: write only gives +1; pop only gives −1; simultaneous write and pop leaves the count unchanged.
- **Clear / reset priority**
  - `reset` is highest priority.
  - `clear` has the same effect as `reset` on all state and takes priority over a same-cycle `done` (that result is discarded and not counted as dropped).
  - Reset/clear mid-handshake abandons the entry in flight.
- **Arithmetic**
  - Pointers are ADDR_W bits, wrapping.
  - `fifo_count` is ADDR_W+1 bits, range 0..DEPTH.
  - `drop_cnt` never wraps.

## Timing
- **Reset values**: `rd_valid`=0, `rd_data`=0, `rd_last`=0, `fifo_count`=0, `overflow`=0, `drop_cnt`=0, FSM=`IDLE`, both pointers=0.
- **Latency**: with the FIFO empty and the FSM in `IDLE`, `done` sampled at edge N gives `fifo_count`=1 after N and `rd_valid`=1 (low word) after edge N+1.
- **Throughput**: one word per cycle with `rd_ready` held high, i.e. one result per 2 cycles.
- `overflow`/`drop_cnt` update at the edge that samples the rejected `done`.
- Full FIFO + `done` in the same cycle as the final `HIGH` handshake: the write is accepted and the count stays at `DEPTH`.
- `done` arriving while the FSM is in `IDLE` with count 0 is written at edge N. The FSM sees count=1 only after that edge; there is no write-through bypass.

## Test plan
- **Single result**
  - Stimulus: `timedata`=64'h0000_0012_3456_789A with `done` at cycle 10; `rd_ready`=1.
  - Required response: `rd_valid` rises at cycle 12 with `rd_data`=32'h3456_789A, `rd_last`=0; cycle 13 gives 32'h0000_0012, `rd_last`=1; cycle 14 `rd_valid`=0 and `fifo_count`=0.
- **Backpressure**
  - Stimulus: `rd_ready`=0 for 5 cycles after `rd_valid` rises, then 1.
  - Required response: `rd_data`/`rd_last` stable throughout; both words are delivered exactly once, in order.
- **Fill and overflow**
  - Stimulus: `rd_ready`=0; 18 `done` pulses with values 1..18.
  - Required response: `fifo_count`=16; `overflow`=1; `drop_cnt`=2. Draining then yields 1..16 in order, with upper words 0.
- **Simultaneous write and pop at full**
  - Stimulus: FIFO full; `done` coincident with a `HIGH` handshake.
  - Required response: write accepted; `fifo_count` stays 16; `drop_cnt` unchanged.
- **Back-to-back delivery**
  - Stimulus: 3 results queued; `rd_ready`=1.
  - Required response: 6 consecutive valid cycles, with no idle cycle between entries.
- **Clear mid-transfer**
  - Stimulus: assert `clear` while in `HIGH` with 4 entries stored and `drop_cnt`=3, with `done` in the same cycle.
  - Required response: next cycle all outputs are at reset values; the same-cycle `done` is not stored or counted. A new `done` afterwards gives `rd_valid` 2 cycles later.
